fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage plus IF/ID pipeline register for the five-stage MIPS core. Holds the PC and drives the instruction-memory address. Captures the fetched word into IF/ID and exposes its OpCode/Funct fields to the ID-stage control decoder. Redirects the PC on EX-resolved branches, ID-resolved jumps and ID-detected illegal instructions, and inserts bubbles as required.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h8000_0008, PC loaded when an illegal instruction is flagged in ID.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  32  current PC; equals `pc`.
- `imem_rdata`  in  32  instruction at `imem_addr`, combinational, same cycle.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `jump_req`  in  1  ID-stage j/jal/jr/jalr decoded and not excepting.
- `jump_target`  in  32  target for `jump_req`.
- `branch_taken`  in  1  EX-stage branch resolved taken.
- `branch_target`  in  32  target for `branch_taken`.
- `exception`  in  1  ID-stage illegal-instruction flag from the control decoder.
- `if_id_instr`  out  32  registered instruction.
- `if_id_pc_plus4`  out  32  registered PC+4 of that instruction.
- `if_id_valid`  out  1  0 = bubble.
- `opcode`  out  6  `if_id_instr[31:26]`, combinational.
- `funct`  out  6  `if_id_instr[5:0]`, combinational.

## Operation
- Next-PC priority, highest first:
  1. `branch_taken` → `branch_target`.
  2. `exception` → `EXC_VECTOR`.
  3. `stall` → hold PC.
  4. `jump_req` → `jump_target`.
  5. Otherwise → PC+4.
- `stall` beats `jump_req`, because a stalled jr/jalr has no valid target yet.
- `branch_taken` beats `stall`, because the EX instruction is older.
- IF/ID load, same priority:
  - `branch_taken` or `exception`: load a bubble.
  - `stall`: hold all three registers.
  - `jump_req`: load a bubble (see Configuration).
  - Otherwise: load `{imem_rdata, pc+4, 1}`.
- Bubble is instr = 32'h0000_0000, pc_plus4 = 0, valid = 0. All-zero decodes as sll $0 and raises no `exception`.
- PC+4 is 32-bit and wraps 32'hFFFF_FFFC → 32'h0000_0000 with no flag.
- No alignment check: targets are used as given.
- Flushing ID/EX on a branch is not this block's job.

## Timing
- Reset (asynchronous, immediate):
  - `pc = RESET_PC`.
  - `if_id_instr = 0`, `if_id_pc_plus4 = 0`, `if_id_valid = 0`.
- Deasserting reset mid-stream restarts fetch at `RESET_PC`.
- Fetch latency: the instruction at PC N appears on `if_id_instr` one cycle after `imem_addr = N`.
- Redirect: the new PC appears on `imem_addr` the cycle after the request. The redirected instruction reaches IF/ID one cycle later.
- Branch penalty is 2 cycles: the IF/ID bubble here plus the ID/EX flush done elsewhere. Jump penalty is 1 cycle.
- All request inputs are sampled only at the rising edge. They are level, not pulse: holding `stall` high keeps the stage frozen indefinitely.
- Simultaneous `stall` and `exception`: the exception wins, and the excepting instruction is not replayed.

## Configuration
- `FETCH_DELAY_SLOT_EN`
  - Defined: on `jump_req` (without branch or exception), IF/ID loads the fetched instruction normally. This gives an architectural delay slot for j/jal/jr/jalr; `branch_taken` still flushes.
  - Undefined: the jump flushes IF/ID to a bubble as described above.

## Structure
- Shared package `cpu_pkg`:
  - `NOP_INSTR` = 32'h0.
  - Default `RESET_PC` and `EXC_VECTOR`.
  - PCSrc encoding constants (seq 3'b000, branch 3'b001, jump 3'b010, jr 3'b011, exception 3'b100), shared with the control decoder.
- One sub-module `pc_next_sel`: combinational priority mux producing the next PC and an IF/ID action (load / hold / bubble). The parent keeps all registers.

## Test plan
- Reset, then 4 free-running cycles with imem returning `addr|32'h2000_0000` → `imem_addr` reads 0, 4, 8, C. `if_id_instr` lags by one cycle with valid = 1.
- `stall` high 3 cycles at PC = 8 → `imem_addr` stays 8. IF/ID holds the instruction from PC 4. Fetch resumes at C.
- `jump_req` with target 32'h0000_0100 at PC = 10 → next PC = 100, next IF/ID is a bubble. With `FETCH_DELAY_SLOT_EN`, IF/ID instead holds the instruction from PC 10.
- `branch_taken` with target 40, together with `stall` and `jump_req`, → next PC = 40 and IF/ID is a bubble.
- `exception` at PC = 20 → next PC = 32'h8000_0008, IF/ID bubble, `opcode` = `funct` = 0 the following cycle.
- Assert `rst_n` low mid-stream between clock edges → all outputs take reset values immediately. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the five-stage MIPS core front end.
//   NOP_INSTR       : all-zero word (sll $0,$0,0), used as the IF/ID bubble
//   RESET_PC_DEF    : default PC after reset
//   EXC_VECTOR_DEF  : default illegal-instruction vector
//   PCSRC_*         : next-PC source encoding, shared with the control decoder
//   ifid_act_e      : what the IF/ID register does on the next edge
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h8000_0008;

  localparam logic [2:0] PCSRC_SEQ    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_JR     = 3'b011;
  localparam logic [2:0] PCSRC_EXC    = 3'b100;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'b00,
    ACT_HOLD   = 2'b01,
    ACT_BUBBLE = 2'b10
  } ifid_act_e;

endpackage

// File: rtl/pc_next_sel.sv
// ----------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC priority mux and IF/ID action select for fetch_stage.
// Optional feature macro: FETCH_DELAY_SLOT_EN (jumps keep the fetched
// instruction in IF/ID as an architectural delay slot).
// Ports:
//   pc            in  32  current PC
//   stall         in  1   hold PC and IF/ID
//   jump_req      in  1   ID-stage jump request
//   jump_target   in  32  jump destination
//   branch_taken  in  1   EX-stage taken branch
//   branch_target in  32  branch destination
//   exception     in  1   ID-stage illegal instruction
//   pc_plus4      out 32  pc + 4 (wraps silently)
//   next_pc       out 32  PC to load on the next edge
//   ifid_act      out 2   IF/ID load / hold / bubble
// ----------------------------------------------------------------------------
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        [31:0] pc,
  input  logic               stall,
  input  logic               jump_req,
  input  logic        [31:0] jump_target,
  input  logic               branch_taken,
  input  logic        [31:0] branch_target,
  input  logic               exception,
  output logic        [31:0] pc_plus4,
  output logic        [31:0] next_pc,
  output ifid_act_e          ifid_act
);

  logic [2:0] pc_src;

  assign pc_plus4 = pc + 32'd4;

  // Branch outranks stall because the EX instruction is older; stall outranks
  // jump because a stalled jr/jalr does not yet have a valid target.
  always_comb begin
    pc_src   = PCSRC_SEQ;
    ifid_act = ACT_LOAD;
    if (branch_taken) begin
      pc_src   = PCSRC_BRANCH;
      ifid_act = ACT_BUBBLE;
    end else if (exception) begin
      pc_src   = PCSRC_EXC;
      ifid_act = ACT_BUBBLE;
    end else if (stall) begin
      ifid_act = ACT_HOLD;
    end else if (jump_req) begin
      pc_src   = PCSRC_JUMP;
`ifdef FETCH_DELAY_SLOT_EN
      ifid_act = ACT_LOAD;
`else
      ifid_act = ACT_BUBBLE;
`endif
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_BRANCH:         next_pc = branch_target;
      PCSRC_EXC:            next_pc = EXC_VECTOR;
      PCSRC_JUMP, PCSRC_JR: next_pc = jump_target;
      default:              next_pc = pc_plus4;
    endcase
    if (ifid_act == ACT_HOLD) next_pc = pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register. Holds the PC, drives
// the instruction-memory address, captures the fetched word into IF/ID and
// exposes opcode/funct to the ID-stage decoder.
// Optional feature macro: FETCH_DELAY_SLOT_EN (see pc_next_sel).
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_addr       out 32  current PC
//   imem_rdata      in  32  instruction at imem_addr (same cycle)
//   stall           in  1   freeze PC and IF/ID
//   jump_req        in  1   ID jump, with jump_target
//   branch_taken    in  1   EX taken branch, with branch_target
//   exception       in  1   ID illegal instruction -> EXC_VECTOR
//   if_id_instr     out 32  registered instruction
//   if_id_pc_plus4  out 32  registered PC+4 of that instruction
//   if_id_valid     out 1   0 = bubble
//   opcode, funct   out 6   fields of if_id_instr
// ----------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exception,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  ifid_act_e   ifid_act;

  pc_next_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_sel (
    .pc            (pc),
    .stall         (stall),
    .jump_req      (jump_req),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exception     (exception),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc),
    .ifid_act      (ifid_act)
  );

  // IF stage: program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  assign imem_addr = pc;

  // IF/ID boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
    end else begin
      case (ifid_act)
        ACT_LOAD: begin
          if_id_instr    <= imem_rdata;
          if_id_pc_plus4 <= pc_plus4;
          if_id_valid    <= 1'b1;
        end
        ACT_BUBBLE: begin
          if_id_instr    <= NOP_INSTR;
          if_id_pc_plus4 <= 32'h0;
          if_id_valid    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign opcode = if_id_instr[31:26];
  assign funct  = if_id_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump_req;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exception;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  logic        mem_hash = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  localparam logic [31:0] EXC_VEC = 32'h8000_0008;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .jump_req       (jump_req),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .exception      (exception),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .opcode         (opcode),
    .funct          (funct)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic h);
    if (h) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return a | 32'h2000_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr, mem_hash);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_edge();
    logic [31:0] word;
    word = mem_word(m_pc, mem_hash);
    if (branch_taken) begin
      m_pc = branch_target; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (exception) begin
      m_pc = EXC_VEC; m_instr = 0; m_pc4 = 0; m_valid = 0;
    end else if (stall) begin
      // everything frozen
    end else if (jump_req) begin
`ifdef FETCH_DELAY_SLOT_EN
      m_instr = word; m_pc4 = m_pc + 4; m_valid = 1;
`else
      m_instr = 0; m_pc4 = 0; m_valid = 0;
`endif
      m_pc = jump_target;
    end else begin
      m_instr = word; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".addr"},  imem_addr, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"},   if_id_pc_plus4, m_pc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
    chk({tag, ".op"},    {26'b0, opcode}, {26'b0, m_instr[31:26]});
    chk({tag, ".fn"},    {26'b0, funct}, {26'b0, m_instr[5:0]});
  endtask

  task automatic idle_inputs();
    stall = 0; jump_req = 0; branch_taken = 0; exception = 0;
    jump_target = 0; branch_target = 0;
  endtask

  // Apply one edge with inputs set at the previous negedge, then check.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;
    chk("pc_start", imem_addr, 32'h0);

    // free-running fetch
    cycle("run1"); chk("run1_pc", imem_addr, 32'h4);
    chk("run1_instr", if_id_instr, 32'h2000_0000);
    cycle("run2"); chk("run2_pc", imem_addr, 32'h8);
    cycle("run3"); chk("run3_pc", imem_addr, 32'hC);
    // back to PC=8 is not possible; restart from reset so stall lands at 8
    rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
    cycle("r1"); cycle("r2");
    chk("at8", imem_addr, 32'h8);

    // stall three cycles at PC=8
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall_pc", imem_addr, 32'h8);
      chk("stall_hold", if_id_instr, 32'h2000_0004);
    end
    stall = 0;
    cycle("resume"); chk("resume_pc", imem_addr, 32'hC);
    cycle("to10"); chk("at10", imem_addr, 32'h10);

    // jump at PC=0x10
    jump_req = 1; jump_target = 32'h100;
    cycle("jump"); chk("jump_pc", imem_addr, 32'h100);
`ifdef FETCH_DELAY_SLOT_EN
    chk("jump_slot", if_id_instr, 32'h2000_0010);
`else
    chk("jump_bub", {31'b0, if_id_valid}, 32'h0);
`endif
    idle_inputs();

    // branch together with stall and jump
    branch_taken = 1; branch_target = 32'h40; stall = 1; jump_req = 1; jump_target = 32'h300;
    cycle("brall"); chk("br_pc", imem_addr, 32'h40);
    chk("br_bub", {31'b0, if_id_valid}, 32'h0);
    idle_inputs();

    // get to PC=0x20 by branching, then raise an exception there
    branch_taken = 1; branch_target = 32'h20;
    cycle("br20"); idle_inputs();
    exception = 1; stall = 1;
    cycle("exc"); chk("exc_pc", imem_addr, EXC_VEC);
    chk("exc_op", {26'b0, opcode}, 32'h0);
    chk("exc_fn", {26'b0, funct}, 32'h0);
    idle_inputs();
    cycle("postexc");

    // wrap of PC+4
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    cycle("towrap"); idle_inputs();
    cycle("wrap"); chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc_plus4, 32'h0);

    // asynchronous reset between edges
    cycle("pre_rst"); cycle("pre_rst2");
    #2 rst_n = 1'b0; #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk); rst_n = 1'b1;
    cycle("rst_restart"); chk("restart_pc", imem_addr, 32'h4);

    // randomized phase
    mem_hash = 1'b1;
    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 99) < 25);
      jump_req      = ($urandom_range(0, 99) < 15);
      branch_taken  = ($urandom_range(0, 99) < 10);
      exception     = ($urandom_range(0, 99) < 8);
      jump_target   = $urandom;
      branch_target = $urandom;
      if (n == 200) begin
        #3 rst_n = 1'b0; #1;
        model_reset();
        compare_all("rand_rst");
        @(negedge clk); rst_n = 1'b1;
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
